// File: rtl/serial_adder32.sv
// Bit-serial adder: one full_adder cell is reused WIDTH times, LSB first,
// with the carry held in a flop between bits. A small IDLE/RUN/DONE FSM
// sequences operand capture, the bit loop and result delivery.

// ---------------------------------------------------------------------------
// full_adder: the single-bit adder cell the serial datapath is built around.
// ---------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum_bit,
  output logic carry_out
);

  logic half_sum;

  // Pure combinational sum/carry of three single-bit inputs.
  always_comb begin
    half_sum  = a ^ b;
    sum_bit   = half_sum ^ carry_in;
    carry_out = (a & b) | (carry_in & half_sum);
  end

endmodule

// ---------------------------------------------------------------------------
// serial_adder32
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both 1. The producer holds valid (and its data) until that edge;
// ready never depends on valid in the same cycle. in_ready is 1 only in IDLE,
// out_valid is 1 only in DONE, so accepting a new operand pair and
// delivering a result can never happen on the same edge. in_valid seen in
// RUN or DONE is dropped, not queued.
// ---------------------------------------------------------------------------
module serial_adder32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter value on the edge that processes the MSB.
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             state_next;

  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   sum_sh;
  logic               carry_reg;
  logic [CNT_W-1:0]   bit_cnt;

  logic               fa_sum;
  logic               fa_carry;
  logic               accept;
  logic               deliver;
  logic               last_bit;
  logic [WIDTH-1:0]   sum_shifted;

  // The one and only adder cell: sees the current LSBs and the held carry.
  full_adder u_fa (
    .a         (a_sh[0]),
    .b         (b_sh[0]),
    .carry_in  (carry_reg),
    .sum_bit   (fa_sum),
    .carry_out (fa_carry)
  );

  // Handshake qualifiers and the shifted sum word, decoded from state.
  always_comb begin
    in_ready    = (state == IDLE);
    out_valid   = (state == DONE);
    accept      = in_valid && in_ready;
    deliver     = out_valid && out_ready;
    last_bit    = (state == RUN) && (bit_cnt == LAST_BIT);
    sum_shifted = {fa_sum, sum_sh[WIDTH-1:1]};
    state_dbg   = state;
  end

  // State register; reset aborts any operation back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept)   state_next = RUN;
      RUN:  if (last_bit) state_next = DONE;
      DONE: if (deliver)  state_next = IDLE;
      default:            state_next = IDLE;
    endcase
  end

  // Operand shift registers, carry flop and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry_reg <= 1'b0;
      bit_cnt   <= '0;
    end else if (accept) begin
      a_sh      <= a;
      b_sh      <= b;
      sum_sh    <= '0;
      carry_reg <= carry_in;
      bit_cnt   <= '0;
    end else if (state == RUN) begin
      a_sh      <= a_sh >> 1;
      b_sh      <= b_sh >> 1;
      sum_sh    <= sum_shifted;
      carry_reg <= fa_carry;
      bit_cnt   <= bit_cnt + CNT_W'(1);
    end
  end

  // Result registers: loaded only when the MSB is processed, so a partial
  // result is never visible; they keep their value after delivery.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (last_bit) begin
      sum       <= sum_shifted;
      carry_out <= fa_carry;
      // carry_reg here is the carry into the MSB.
      overflow  <= carry_reg ^ fa_carry;
    end
  end

endmodule

// File: tb/tb_serial_adder32.sv
// Self-checking bench for serial_adder32: directed corner cases plus random
// operations against a plain-arithmetic reference model.
module tb_serial_adder32;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder32 #(.WIDTH(W), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [W+1:0] exp_q[$];   // {overflow, carry_out, sum}
  int n_checks = 0;
  int n_errors = 0;
  int last_rise = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: plain wide addition; signed overflow when both operands share
  // a sign and the result sign differs.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci);
    logic [W:0] s;
    logic       ovf;
    s   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    ovf = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    return {ovf, s[W], s[W-1:0]};
  endfunction

  // ---------------- driver tasks ----------------
  // Wait for in_ready, present one operand pair, return just after accept.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("send_ready", in_ready, 1'b1);
    in_valid = 1'b1; a = x; b = y; carry_in = ci;
    exp_q.push_back(ref_add(x, y, ci));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called right after send: measure latency, optionally disturb inputs in
  // RUN, apply hold cycles of backpressure, then take the result.
  task automatic collect(input int hold, input bit disturb);
    int lat = 0;
    logic [W+1:0] exp;
    logic [W+1:0] seen;
    out_ready = (hold == 0);
    do begin
      if (disturb && lat < 30) begin
        a = $urandom; b = $urandom; carry_in = $urandom_range(0, 1);
        in_valid = $urandom_range(0, 1);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1; lat++;
      if (!out_valid && disturb) check("run_in_ready", in_ready, 1'b0);
    end while (!out_valid && lat < 40);
    in_valid = 1'b0;
    check("latency", lat, W);
    last_rise = cyc;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 1, 0);
      return;
    end
    exp = exp_q.pop_front();
    seen = {overflow, carry_out, sum};
    check("sum", sum, exp[W-1:0]);
    check("carry_out", carry_out, exp[W]);
    check("overflow", overflow, exp[W+1]);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_stable", {overflow, carry_out, sum}, seen);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_valid", out_valid, 1'b0);
    check("post_in_ready", in_ready, 1'b1);
    check("post_keep", {overflow, carry_out, sum}, seen);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r1;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_outputs", {overflow, carry_out, sum}, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rel_in_ready", in_ready, 1'b1);

    // Directed corner cases.
    send(32'h0000_0000, 32'h0000_0000, 1'b0); collect(0, 1'b0);
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0); collect(0, 1'b0);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0); collect(0, 1'b0);
    send(32'h1234_5678, 32'h9ABC_DEF0, 1'b1); collect(0, 1'b1);
    check("known_sum", sum, 32'hACF1_3569);
    send(32'h8000_0000, 32'h8000_0000, 1'b0); collect(5, 1'b0);

    // Back-to-back: results appear WIDTH+2 cycles apart.
    send(32'hDEAD_BEEF, 32'h1111_1111, 1'b0); collect(0, 1'b0);
    r1 = last_rise;
    send(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1); collect(0, 1'b0);
    check("b2b_interval", last_rise - r1, W + 2);

    // Reset in the middle of an operation.
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_outputs", {overflow, carry_out, sum}, '0);
    check("abort_in_ready", in_ready, 1'b1);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_rel_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    check("abort_idle_valid", out_valid, 1'b0);
    send(32'd3, 32'd4, 1'b0); collect(0, 1'b0);
    check("fresh_sum", sum, 32'd7);

    // Random operations with random backpressure and input disturbance.
    for (int i = 0; i < 24; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)));
      collect($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete in time (cycle %0d)", cyc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
